demux_lane_sequencer: RTL and testbench



---
 rtl/demux_lane_sequencer.sv | 127 ++++++++++++
 tb/tb_demux_lane_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_lane_sequencer.sv
// Feeds a 1-to-4 demux one lane per accepted word and mirrors the lanes as a
// parallel, handshaked group; flush closes a partial group with empty lanes at 0.
module demux_lane_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] demux_data,
  output logic [3:0]       lane_load,
  output logic [WIDTH-1:0] out_1,
  output logic [WIDTH-1:0] out_2,
  output logic [WIDTH-1:0] out_3,
  output logic [WIDTH-1:0] out_4,
  output logic [3:0]       out_mask,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [1:0]       sel_reg, sel_next;
  logic [WIDTH-1:0] demux_data_reg, demux_data_next;
  logic [3:0]       lane_load_reg, lane_load_next;
  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] lane_reg [4];
  logic [3:0]       mask_reg;
  logic             accept;
  logic             consume;

  assign in_ready = rst_n & (state_reg == FILL);
  assign accept   = in_valid & in_ready;
  assign consume  = (state_reg == FULL) & out_valid_reg & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= FILL;
      ptr_reg        <= 2'd0;
      sel_reg        <= 2'd0;
      demux_data_reg <= '0;
      lane_load_reg  <= 4'd0;
      out_valid_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ptr_reg        <= ptr_next;
      sel_reg        <= sel_next;
      demux_data_reg <= demux_data_next;
      lane_load_reg  <= lane_load_next;
      out_valid_reg  <= out_valid_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    ptr_next        = ptr_reg;
    sel_next        = sel_reg;
    demux_data_next = demux_data_reg;
    lane_load_next  = 4'd0;
    out_valid_next  = out_valid_reg;
    case (state_reg)
      FILL: begin
        if (accept) begin
          sel_next        = ptr_reg;
          demux_data_next = in_data;
          lane_load_next  = 4'b0001 << ptr_reg;
          ptr_next        = ptr_reg + 2'd1;
          if (ptr_reg == 2'd3 || flush) begin
            state_next     = FULL;
            out_valid_next = 1'b1;
            ptr_next       = 2'd0;
          end
        end else if (flush && mask_reg != 4'd0) begin
          // An empty flush is dropped so the consumer never sees a zero-lane group.
          state_next     = FULL;
          out_valid_next = 1'b1;
          ptr_next       = 2'd0;
        end
      end
      FULL: begin
        if (consume) begin
          state_next     = FILL;
          out_valid_next = 1'b0;
        end
      end
      default: begin
        state_next     = FILL;
        out_valid_next = 1'b0;
        ptr_next       = 2'd0;
      end
    endcase
  end

  // Lanes clear on consume so a later flushed group reads 0 in unwritten lanes.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          lane_reg[gi] <= '0;
          mask_reg[gi] <= 1'b0;
        end else if (consume) begin
          lane_reg[gi] <= '0;
          mask_reg[gi] <= 1'b0;
        end else if (accept && ptr_reg == 2'(gi)) begin
          lane_reg[gi] <= in_data;
          mask_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  assign sel        = sel_reg;
  assign demux_data = demux_data_reg;
  assign lane_load  = lane_load_reg;
  assign out_1      = lane_reg[0];
  assign out_2      = lane_reg[1];
  assign out_3      = lane_reg[2];
  assign out_4      = lane_reg[3];
  assign out_mask   = mask_reg;
  assign out_valid  = out_valid_reg;

endmodule

// File: tb/tb_demux_lane_sequencer.sv
// Directed bench for demux_lane_sequencer: fill, hold, flush, reset and a
// randomized-valid stream with an in-order group scoreboard.
module tb_demux_lane_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic [1:0]  sel;
  logic [15:0] demux_data;
  logic [3:0]  lane_load;
  logic [15:0] out_1, out_2, out_3, out_4;
  logic [3:0]  out_mask;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  demux_lane_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .sel(sel), .demux_data(demux_data),
    .lane_load(lane_load), .out_1(out_1), .out_2(out_2), .out_3(out_3),
    .out_4(out_4), .out_mask(out_mask), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({out_valid, out_mask, lane_load, sel, in_ready} !== 12'd0 ||
        {out_1, out_2, out_3, out_4, demux_data} !== 80'd0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%b mask=%b load=%b sel=%0d rdy=%b lanes=%h/%h/%h/%h dd=%h want all 0",
               out_valid, out_mask, lane_load, sel, in_ready, out_1, out_2, out_3, out_4, demux_data);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got %b want 1", in_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_full_group();
    logic [15:0] words [4];
    words[0] = 16'h0011; words[1] = 16'h0022; words[2] = 16'h0033; words[3] = 16'h0044;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      tick();
      checks++;
      if (sel !== 2'(i) || lane_load !== (4'b0001 << i) || demux_data !== words[i]) begin
        failures++;
        $display("FAIL fill_word%0d got sel=%0d load=%b dd=%h want sel=%0d load=%b dd=%h",
                 i, sel, lane_load, demux_data, i, 4'b0001 << i, words[i]);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_mask !== 4'b1111 || in_ready !== 1'b0 ||
        {out_1, out_2, out_3, out_4} !== 64'h0011_0022_0033_0044) begin
      failures++;
      $display("FAIL full_group got v=%b m=%b rdy=%b lanes=%h/%h/%h/%h want v=1 m=1111 rdy=0 lanes=0011/0022/0033/0044",
               out_valid, out_mask, in_ready, out_1, out_2, out_3, out_4);
    end
    tick();
    checks++;
    if (lane_load !== 4'd0) begin
      failures++;
      $display("FAIL load_pulse_width got %b want 0000", lane_load);
    end
    $display("test_full_group done");
  endtask

  task automatic test_hold_and_consume();
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_mask !== 4'b1111 || in_ready !== 1'b0 ||
          {out_1, out_2, out_3, out_4} !== 64'h0011_0022_0033_0044) begin
        failures++;
        $display("FAIL hold_cycle%0d got v=%b m=%b rdy=%b lanes=%h/%h/%h/%h want stable full group",
                 c, out_valid, out_mask, in_ready, out_1, out_2, out_3, out_4);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_mask !== 4'd0 || in_ready !== 1'b1 ||
        {out_1, out_2, out_3, out_4} !== 64'd0) begin
      failures++;
      $display("FAIL consume_clear got v=%b m=%b rdy=%b lanes=%h/%h/%h/%h want v=0 m=0 rdy=1 lanes 0",
               out_valid, out_mask, in_ready, out_1, out_2, out_3, out_4);
    end
    in_valid = 1'b1;
    in_data  = 16'h0055;
    tick();
    in_valid = 1'b0;
    checks++;
    if (sel !== 2'd0 || lane_load !== 4'b0001 || out_1 !== 16'h0055 || out_mask !== 4'b0001) begin
      failures++;
      $display("FAIL next_word_lane0 got sel=%0d load=%b out_1=%h m=%b want sel=0 load=0001 out_1=0055 m=0001",
               sel, lane_load, out_1, out_mask);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_mask !== 4'b0001 || out_2 !== 16'd0) begin
      failures++;
      $display("FAIL single_flush got v=%b m=%b out_2=%h want v=1 m=0001 out_2=0", out_valid, out_mask, out_2);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("test_hold_and_consume done");
  endtask

  task automatic test_flush_partial();
    in_valid = 1'b1;
    in_data  = 16'hAAAA;
    tick();
    in_data  = 16'hBBBB;
    tick();
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_mask !== 4'b0011 ||
        {out_1, out_2, out_3, out_4} !== 64'hAAAA_BBBB_0000_0000) begin
      failures++;
      $display("FAIL flush_partial got v=%b m=%b lanes=%h/%h/%h/%h want v=1 m=0011 lanes=AAAA/BBBB/0000/0000",
               out_valid, out_mask, out_1, out_2, out_3, out_4);
    end
    checks++;
    if (sel !== 2'd1 || demux_data !== 16'hBBBB || lane_load !== 4'd0) begin
      failures++;
      $display("FAIL flush_demux_hold got sel=%0d dd=%h load=%b want sel=1 dd=BBBB load=0000",
               sel, demux_data, lane_load);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_mask !== 4'b0011 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_in_full got v=%b m=%b rdy=%b want v=1 m=0011 rdy=0", out_valid, out_mask, in_ready);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("test_flush_partial done");
  endtask

  task automatic test_flush_edges();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL empty_flush got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0100 + 16'(i);
      flush    = (i == 3);
      tick();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_mask !== 4'b1111 ||
        {out_1, out_2, out_3, out_4} !== 64'h0100_0101_0102_0103) begin
      failures++;
      $display("FAIL flush_with_4th got v=%b m=%b lanes=%h/%h/%h/%h want v=1 m=1111 lanes=0100/0101/0102/0103",
               out_valid, out_mask, out_1, out_2, out_3, out_4);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_group_after_flush got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    in_valid = 1'b1;
    in_data  = 16'h0200;
    tick();
    in_data  = 16'h0201;
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_mask !== 4'b0011 ||
        {out_1, out_2, out_3, out_4} !== 64'h0200_0201_0000_0000) begin
      failures++;
      $display("FAIL flush_with_2nd got v=%b m=%b lanes=%h/%h/%h/%h want v=1 m=0011 lanes=0200/0201/0000/0000",
               out_valid, out_mask, out_1, out_2, out_3, out_4);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h0300;
    tick();
    in_valid = 1'b0;
    checks++;
    if (sel !== 2'd0 || lane_load !== 4'b0001 || out_mask !== 4'b0001) begin
      failures++;
      $display("FAIL ptr_reset_after_flush got sel=%0d load=%b m=%b want sel=0 load=0001 m=0001",
               sel, lane_load, out_mask);
    end
    $display("test_flush_edges done");
  endtask

  task automatic test_reset_mid_group();
    in_valid = 1'b1;
    in_data  = 16'h0E01;
    tick();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    tick();
    checks++;
    if ({out_valid, out_mask, lane_load, sel, in_ready} !== 12'd0 ||
        {out_1, out_2, out_3, out_4, demux_data} !== 80'd0) begin
      failures++;
      $display("FAIL reset_mid_group got v=%b m=%b load=%b sel=%0d rdy=%b lanes=%h/%h/%h/%h dd=%h want all 0",
               out_valid, out_mask, lane_load, sel, in_ready, out_1, out_2, out_3, out_4, demux_data);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0F00 + 16'(i);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_mask !== 4'b1111 ||
        {out_1, out_2, out_3, out_4} !== 64'h0F00_0F01_0F02_0F03) begin
      failures++;
      $display("FAIL fresh_group got v=%b m=%b lanes=%h/%h/%h/%h want v=1 m=1111 lanes=0F00/0F01/0F02/0F03",
               out_valid, out_mask, out_1, out_2, out_3, out_4);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    $display("test_reset_mid_group done");
  endtask

  task automatic test_back_to_back();
    int accepted = 0;
    int groups = 0;
    int cyc = 0;
    logic acc;
    logic [63:0] want;
    out_ready = 1'b1;
    while (accepted < 40 && cyc < 1000) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 16'h1000 + 16'(accepted);
      #1;
      acc = in_valid & in_ready;
      tick();
      cyc++;
      if (acc) accepted++;
      if (out_valid) begin
        want = {16'h1000 + 16'(groups * 4), 16'h1000 + 16'(groups * 4 + 1),
                16'h1000 + 16'(groups * 4 + 2), 16'h1000 + 16'(groups * 4 + 3)};
        checks++;
        if ({out_1, out_2, out_3, out_4} !== want || out_mask !== 4'b1111) begin
          failures++;
          $display("FAIL stream_group%0d got lanes=%h/%h/%h/%h m=%b want %h m=1111",
                   groups, out_1, out_2, out_3, out_4, out_mask, want);
        end
        groups++;
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    checks++;
    if (groups !== 10 || accepted !== 40) begin
      failures++;
      $display("FAIL stream_count got groups=%0d words=%0d want groups=10 words=40", groups, accepted);
    end
    $display("test_back_to_back done");
  endtask

  initial begin
    test_reset();
    test_full_group();
    test_hold_and_consume();
    test_flush_partial();
    test_flush_edges();
    test_reset_mid_group();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
